// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, owner encoding and defaults for the CPU/VGA memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 16;
  localparam int MAX_WAIT_DEF = 8;
  localparam int CNT_W        = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the CPU has been kept waiting.
module arb_starve_cnt #(
  parameter int MAX_WAIT = mem_port_arbiter_pkg::MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic gnt_i,
  output logic sat_o
);
  import mem_port_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between a CPU and a VGA scan-out reader, one access per cycle.
module mem_port_arbiter #(
  parameter int ADDR_W   = mem_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = mem_port_arbiter_pkg::DATA_W,
  parameter int MAX_WAIT = mem_port_arbiter_pkg::MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  input  logic              vga_urgent_i,
  output logic              vga_gnt_o,
  output logic              vga_rvalid_o,
  output logic [DATA_W-1:0] vga_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  import mem_port_arbiter_pkg::*;

  logic              cpu_gnt, vga_gnt, cpu_sat;
  owner_e            last_gnt_q, last_gnt_d;
  logic              rd_pend_q, rd_pend_d;
  owner_e            rd_own_q, rd_own_d;
  logic              cpu_rvalid, vga_rvalid;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, vga_rdata_q, vga_rdata_d;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .req_i (cpu_req_i),
    .gnt_i (cpu_gnt),
    .sat_o (cpu_sat)
  );

  // Tie order: starved CPU, then urgent VGA, then whoever was not granted last.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (reset) begin
      if (cpu_req_i && vga_req_i) begin
        if (cpu_sat) begin
          cpu_gnt = 1'b1;
        end else if (vga_urgent_i) begin
          vga_gnt = 1'b1;
        end else if (last_gnt_q == OWN_CPU) begin
          vga_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req_i;
        vga_gnt = vga_req_i;
      end
    end
  end

  always_comb begin
    mem_en_o    = cpu_gnt | vga_gnt;
    mem_we_o    = cpu_gnt & cpu_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (vga_gnt) begin
      mem_addr_o  = vga_addr_i;
    end
  end

  // A return pending across a reset edge is suppressed by gating with reset.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (cpu_gnt) begin
      last_gnt_d = OWN_CPU;
    end else if (vga_gnt) begin
      last_gnt_d = OWN_VGA;
    end
    rd_pend_d   = (cpu_gnt & ~cpu_we_i) | vga_gnt;
    rd_own_d    = vga_gnt ? OWN_VGA : OWN_CPU;
    cpu_rvalid  = reset & rd_pend_q & (rd_own_q == OWN_CPU);
    vga_rvalid  = reset & rd_pend_q & (rd_own_q == OWN_VGA);
    cpu_rdata_d = cpu_rvalid ? mem_rdata_i : cpu_rdata_q;
    vga_rdata_d = vga_rvalid ? mem_rdata_i : vga_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_gnt_q  <= OWN_VGA;
      rd_pend_q   <= 1'b0;
      rd_own_q    <= OWN_CPU;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_own_q    <= rd_own_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign vga_gnt_o    = vga_gnt;
  assign cpu_rvalid_o = cpu_rvalid;
  assign vga_rvalid_o = vga_rvalid;
  assign cpu_rdata_o  = cpu_rdata_d;
  assign vga_rdata_o  = vga_rdata_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory on the port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        vga_req, vga_urgent, vga_gnt, vga_rvalid;
  logic [14:0] vga_addr;
  logic [15:0] vga_rdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .vga_req_i(vga_req), .vga_addr_i(vga_addr), .vga_urgent_i(vga_urgent),
    .vga_gnt_o(vga_gnt), .vga_rvalid_o(vga_rvalid), .vga_rdata_o(vga_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Memory: fixed pattern everywhere, 0xBEEF at 0x0010, plus the most recent write.
  logic        wr_seen = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  function automatic logic [15:0] rom(input logic [14:0] a);
    if (a == 15'h0010) return 16'hBEEF;
    return {1'b0, a} ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_seen <= 1'b1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end else begin
        mem_rdata <= (wr_seen && mem_addr == wr_addr) ? wr_data : rom(mem_addr);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 0; vga_addr = '0; vga_urgent = 0;
  endtask

  task automatic apply_reset();
    reset = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0123; cpu_wdata = 16'hAAAA;
    vga_req = 1; vga_addr = 15'h0456; vga_urgent = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, vga_gnt, mem_en, mem_we} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_gnt: got gnt/en/we=%b expected 0000", {cpu_gnt, vga_gnt, mem_en, mem_we});
    end
    vectors++;
    if ({cpu_rvalid, vga_rvalid} !== 2'b00 || cpu_rdata !== 16'h0 || vga_rdata !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_rd: got rvalid=%b cpu_rdata=%h vga_rdata=%h expected 00 0000 0000",
               {cpu_rvalid, vga_rvalid}, cpu_rdata, vga_rdata);
    end
    next_cycle();
    reset = 1;
    cpu_req = 0; vga_req = 0;
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b0 || mem_addr !== 15'h0 || mem_wdata !== 16'h0) begin
      miscompares++;
      $display("FAIL idle_port: got en=%b addr=%h wdata=%h expected 0 0000 0000", mem_en, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_cpu_read();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010; vga_urgent = 1;
    @(negedge clk);
    vectors++;
    if (cpu_gnt !== 1'b1 || vga_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h0010) begin
      miscompares++;
      $display("FAIL cpu_read_issue: got gnt=%b%b en=%b we=%b addr=%h expected 10 1 0 0010",
               cpu_gnt, vga_gnt, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    vectors++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF || vga_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_read_return: got rvalid=%b rdata=%h vga_rvalid=%b expected 1 beef 0",
               cpu_rvalid, cpu_rdata, vga_rvalid);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL cpu_rdata_hold: got rvalid=%b rdata=%h expected 0 beef", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0020;
    vga_req = 1; vga_addr = 15'h0030; vga_urgent = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== (i % 2 == 0) || vga_gnt !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL alt_gnt[%0d]: got cpu=%b vga=%b expected cpu=%b", i, cpu_gnt, vga_gnt, (i % 2 == 0));
      end
      if (i > 0) begin
        vectors++;
        if (i % 2 == 1 && (cpu_rvalid !== 1'b1 || vga_rvalid !== 1'b0 || cpu_rdata !== 16'h5A7A)) begin
          miscompares++;
          $display("FAIL alt_ret[%0d]: got rv=%b%b cpu_rdata=%h expected 10 5a7a", i, cpu_rvalid, vga_rvalid, cpu_rdata);
        end else if (i % 2 == 0 && (vga_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || vga_rdata !== 16'h5A6A)) begin
          miscompares++;
          $display("FAIL alt_ret[%0d]: got rv=%b%b vga_rdata=%h expected 01 5a6a", i, cpu_rvalid, vga_rvalid, vga_rdata);
        end
      end
      next_cycle();
    end
    cpu_req = 0; vga_req = 0;
    @(negedge clk);
    vectors++;
    if (vga_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || vga_rdata !== 16'h5A6A) begin
      miscompares++;
      $display("FAIL alt_last_ret: got rv=%b%b vga_rdata=%h expected 01 5a6a", cpu_rvalid, vga_rvalid, vga_rdata);
    end
  endtask

  task automatic test_urgent_starve();
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0040;
    vga_req = 1; vga_addr = 15'h0050; vga_urgent = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== (i == 8) || vga_gnt !== (i != 8)) begin
        miscompares++;
        $display("FAIL starve[%0d]: got cpu=%b vga=%b expected cpu=%b", i, cpu_gnt, vga_gnt, (i == 8));
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_wait_clear();
    apply_reset();
    cpu_req = 1; cpu_addr = 15'h0040;
    vga_req = 1; vga_addr = 15'h0050; vga_urgent = 1;
    repeat (5) next_cycle();
    cpu_req = 0;
    @(negedge clk);
    vectors++;
    if (vga_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_gnt: got cpu=%b vga=%b expected 0 1", cpu_gnt, vga_gnt);
    end
    next_cycle();
    cpu_req = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== (i == 8)) begin
        miscompares++;
        $display("FAIL wait_clear[%0d]: got cpu_gnt=%b expected %b", i, cpu_gnt, (i == 8));
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    apply_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h7FFF; cpu_wdata = 16'h1234;
    @(negedge clk);
    vectors++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h7FFF || mem_wdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL wr_issue: got gnt=%b we=%b addr=%h wdata=%h expected 1 1 7fff 1234",
               cpu_gnt, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    cpu_req = 0; cpu_we = 0;
    vga_req = 1; vga_addr = 15'h7FFF;
    @(negedge clk);
    vectors++;
    if (vga_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h7FFF || cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL vga_rd_issue: got gnt=%b we=%b addr=%h cpu_rvalid=%b expected 1 0 7fff 0",
               vga_gnt, mem_we, mem_addr, cpu_rvalid);
    end
    next_cycle();
    vga_req = 0;
    @(negedge clk);
    vectors++;
    if (vga_rvalid !== 1'b1 || vga_rdata !== 16'h1234 || cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL vga_rd_return: got rvalid=%b rdata=%h cpu_rvalid=%b expected 1 1234 0",
               vga_rvalid, vga_rdata, cpu_rvalid);
    end
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    vga_req = 1; vga_addr = 15'h0030;
    @(negedge clk);
    vectors++;
    if (vga_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_issue: got vga_gnt=%b expected 1", vga_gnt);
    end
    next_cycle();
    reset = 0;
    cpu_req = 1; cpu_addr = 15'h0020;
    @(negedge clk);
    vectors++;
    if (vga_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || vga_gnt !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_drop: got vga_rvalid=%b gnt=%b%b en=%b expected 0 00 0",
               vga_rvalid, cpu_gnt, vga_gnt, mem_en);
    end
    next_cycle();
    next_cycle();
    reset = 1;
    @(negedge clk);
    vectors++;
    if (cpu_gnt !== 1'b1 || vga_gnt !== 1'b0 || vga_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_tie: got cpu=%b vga=%b vga_rvalid=%b expected 1 0 0", cpu_gnt, vga_gnt, vga_rvalid);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_alternate();
    test_urgent_starve();
    test_wait_clear();
    test_write_read();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, 15, memory word address width; DATA_W, 16, data width; MAX_WAIT, 8, CPU starvation limit in cycles (range 1..255).
REQ-002 Ports, one per line; the fixed clock/reset rule is: reset reset, synchronous, active-low; clock clk.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- vga_req  in  1  VGA framebuffer read request, held until vga_gnt
- vga_addr  in  ADDR_W  VGA word address
- vga_urgent  in  1  VGA in active scan; raises VGA priority
- vga_gnt  out  1  VGA access issued this cycle
- vga_rvalid  out  1  VGA read data valid
- vga_rdata  out  DATA_W  VGA read data
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read issue

Function
REQ-003 Exactly one access per cycle: cpu_gnt and vga_gnt are never both 1.
REQ-004 Grant is combinational from the current cycle's requests and the registered state; mem_en/mem_we/mem_addr/mem_wdata are driven in the same cycle from the granted requester.
REQ-005 No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-006 VGA accesses are always reads: mem_we=0 on a VGA grant.
REQ-007 Priority when both request, evaluated in order: (1) cpu_wait==MAX_WAIT -> CPU; (2) vga_urgent=1 -> VGA; (3) otherwise the requester not granted last (last_gnt pointer).
REQ-008 A single requester is granted immediately, regardless of vga_urgent or last_gnt.
REQ-009 cpu_wait: an 8-bit counter, +1 each cycle cpu_req=1 and cpu_gnt=0, saturating at MAX_WAIT; cleared on cpu_gnt or cpu_req=0.
REQ-010 last_gnt updates only on a grant cycle (0=CPU, 1=VGA); it holds on idle cycles.
REQ-011 Read latency is exactly 1: a read granted in cycle N asserts the owner's rvalid in N+1 with rdata=mem_rdata; the other rvalid stays 0.
REQ-012 A granted write asserts no rvalid; cpu_rdata/vga_rdata keep their last valid value while rvalid=0.
REQ-013 Back-to-back grants to alternating requesters on consecutive cycles are allowed; the read-return owner tag is pipelined one cycle so returns never cross.
REQ-014 A requester that drops req before gnt is not granted; no state is held for it apart from clearing cpu_wait.

Reset
REQ-015 While reset=0 at a clock edge: cpu_wait=0, last_gnt=1 (CPU wins the first tie), read-owner pipeline cleared, cpu_rvalid=vga_rvalid=0, cpu_rdata=vga_rdata=0.
REQ-016 During reset=0, cpu_gnt=vga_gnt=0 and mem_en=mem_we=0 combinationally, regardless of requests.
REQ-017 Reset asserted with a read in flight discards that read: no rvalid in the following cycle.

Structure
REQ-018 The shared package holds ADDR_W, DATA_W, the owner encoding (OWN_CPU=0, OWN_VGA=1), and the default MAX_WAIT.
REQ-019 One sub-module, arb_starve_cnt, implements the saturating cpu_wait counter; all other logic stays in mem_port_arbiter.

Verification
REQ-020 CPU-only read, addr 0x0010, memory word 0xBEEF -> cpu_gnt in cycle N, mem_addr=0x0010, mem_we=0; cpu_rvalid=1 with cpu_rdata=0xBEEF in N+1; vga_rvalid=0.
REQ-021 Both requesting, vga_urgent=0, from reset -> grants alternate CPU, VGA, CPU, VGA on 4 consecutive cycles; each rvalid appears 1 cycle after its grant.
REQ-022 vga_urgent=1 and both requesting continuously, MAX_WAIT=8 -> VGA granted 8 cycles, CPU granted on the 9th, then VGA resumes.
REQ-023 CPU write of 0x1234 to 0x7FFF alongside a VGA read of 0x7FFF next cycle -> mem_we=1 then 0; vga_rdata=0x1234; no cpu_rvalid.
REQ-024 reset=0 in the cycle after a VGA read grant -> vga_rvalid stays 0, no grants during reset; after release, a tie is granted to the CPU.
